// File: rtl/pakin_chk_pkg.sv
// ---------------------------------------------------------------------------
// pakin_chk_pkg
//
// Shared definitions for the message-channel sink/checker (pakin_chk):
//   - message field sizes used as the default widths of the channel
//   - on/off levels for handshake wires
//   - checker FSM state encoding
//   - bit positions inside the 3-bit error-kind vector
//   - the destination stepping rule shared with the packet sources
//
// No ports: this is a package imported with import pakin_chk_pkg::*.
// ---------------------------------------------------------------------------
package pakin_chk_pkg;

    // Handshake levels
    localparam logic NS_ON  = 1'b1;
    localparam logic NS_OFF = 1'b0;

    // Default message field sizes
    localparam int NS_ADDRESS_SIZE = 6;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 4;

    // Error-kind vector layout: {redun, dst, dat}
    localparam int NS_CHK_KIND_W    = 3;
    localparam int NS_CHK_BIT_REDUN = 2;
    localparam int NS_CHK_BIT_DST   = 1;
    localparam int NS_CHK_BIT_DAT   = 0;

    // Value shown on the "last data" output before any message arrives,
    // so the LEDs are visibly lit after reset.
    localparam int unsigned NS_CHK_RST_CK_DAT = 15;

    // Checker FSM states
    typedef enum logic [1:0] {
        NS_CHK_IDLE  = 2'd0,
        NS_CHK_CHECK = 2'd1,
        NS_CHK_HOLD  = 2'd2,
        NS_CHK_ACK   = 2'd3
    } ns_chk_state_t;

    // Destination stepping rule of the packet sources: walk upward through
    // [min_addr, max_addr] and wrap back to min_addr.
    function automatic int unsigned ns_chk_nxt_addr(
        input int unsigned adr,
        input int unsigned min_addr,
        input int unsigned max_addr
    );
        return (adr >= max_addr) ? min_addr : adr + 1;
    endfunction

endpackage

// File: rtl/pakin_chk_calc_redun.sv
// ---------------------------------------------------------------------------
// calc_redun
//
// Redundancy field generator shared by the packet sources and the checker.
// The message fields are concatenated as {src, dst, dat} (dat in the LSBs)
// and folded into RSZ bits: output bit j is the parity of every
// concatenated bit whose position is congruent to j modulo RSZ.
//
// Ports:
//   src  in  ASZ  message source address
//   dst  in  ASZ  message destination address
//   dat  in  DSZ  message data
//   red  out RSZ  redundancy computed from the three fields (combinational)
// ---------------------------------------------------------------------------
module calc_redun
    import pakin_chk_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
) (
    input  logic [ASZ-1:0] src,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] red
);

    localparam int TW = 2 * ASZ + DSZ;

    logic [TW-1:0] fields;

    // Parity fold of the concatenated fields into RSZ columns.
    always_comb begin
        fields = {src, dst, dat};
        red    = '0;
        for (int j = 0; j < RSZ; j++) begin
            for (int k = j; k < TW; k += RSZ) begin
                red[j] = red[j] ^ fields[k];
            end
        end
    end

endmodule

// File: rtl/pakin_chk.sv
// ---------------------------------------------------------------------------
// pakin_chk
//
// Sink and checker for the req/ack message channel driven by the test
// packet sources. Each message is taken with a four-phase handshake, its
// redundancy is recomputed, and its destination and data are compared with
// the stepping rules of the source. Results go to LEDs / debug pins.
//
// Parameters:
//   MIN_ADDR, MAX_ADDR  legal destination range, also the stepping range
//   ASZ, DSZ, RSZ       address / data / redundancy field widths (DSZ >= 4)
//   ACK_DLY             extra cycles between the check and ack rise (0..15)
//   CSZ                 message counter width
//
// Ports:
//   i_clk        in   1    main clock
//   i_rst_n      in   1    asynchronous active-low reset
//   i_src        in   ASZ  message source address
//   i_dst        in   ASZ  message destination address
//   i_dat        in   DSZ  message data
//   i_red        in   RSZ  message redundancy
//   i_req        in   1    source request
//   o_ack        out  1    sink acknowledge
//   o_ck_dat     out  DSZ  data of the last accepted message
//   o_cnt        out  CSZ  accepted-message count (wraps)
//   o_err        out  1    sticky: some check has failed
//   o_err_kind   out  3    sticky OR of failures {redun, dst, dat}
//   fst_err_inp  out  DSZ  expected data at the first failure
//   fst_err_dat  out  DSZ  received data at the first failure
//
// All outputs are registered; nothing on i_* reaches an output in the same
// cycle.
// ---------------------------------------------------------------------------
module pakin_chk
    import pakin_chk_pkg::*;
#(
    parameter int unsigned MIN_ADDR = 1,
    parameter int unsigned MAX_ADDR = 1,
    parameter int          ASZ      = NS_ADDRESS_SIZE,
    parameter int          DSZ      = NS_DATA_SIZE,
    parameter int          RSZ      = NS_REDUN_SIZE,
    parameter int unsigned ACK_DLY  = 0,
    parameter int          CSZ      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [ASZ-1:0]           i_src,
    input  logic [ASZ-1:0]           i_dst,
    input  logic [DSZ-1:0]           i_dat,
    input  logic [RSZ-1:0]           i_red,
    input  logic                     i_req,
    output logic                     o_ack,
    output logic [DSZ-1:0]           o_ck_dat,
    output logic [CSZ-1:0]           o_cnt,
    output logic                     o_err,
    output logic [NS_CHK_KIND_W-1:0] o_err_kind,
    output logic [DSZ-1:0]           fst_err_inp,
    output logic [DSZ-1:0]           fst_err_dat
);

    // Destination expected for the very first message after reset.
    localparam logic [ASZ-1:0] RST_EXP_DST =
        ASZ'(ns_chk_nxt_addr(MIN_ADDR, MIN_ADDR, MAX_ADDR));

    // Last value of the HOLD counter before moving on to ACK.
    localparam logic [3:0] HOLD_LAST =
        4'((ACK_DLY == 0) ? 0 : ACK_DLY - 1);

    ns_chk_state_t state;

    // Message fields captured in IDLE; everything checked comes from here,
    // so the source may change i_* freely once the message is latched.
    logic [ASZ-1:0] lat_src;
    logic [ASZ-1:0] lat_dst;
    logic [DSZ-1:0] lat_dat;
    logic [RSZ-1:0] lat_red;

    // Prediction of the next message, resynced to every received message.
    logic [ASZ-1:0] exp_dst;
    logic [3:0]     exp_dat;

    logic [3:0]     hold_cnt;

    logic [RSZ-1:0]           calc_red;
    logic                     bad_redun;
    logic                     bad_dst;
    logic                     bad_dat;
    logic [NS_CHK_KIND_W-1:0] bad_kind;

    calc_redun #(
        .ASZ (ASZ),
        .DSZ (DSZ),
        .RSZ (RSZ)
    ) u_calc_redun (
        .src (lat_src),
        .dst (lat_dst),
        .dat (lat_dat),
        .red (calc_red)
    );

    // The three checks on the latched message. They are only consumed in
    // CHECK, where the latched fields are one cycle old and stable.
    always_comb begin
        bad_redun = (calc_red != lat_red);
        bad_dst   = (lat_dst != exp_dst)
                 || (32'(lat_dst) < MIN_ADDR)
                 || (32'(lat_dst) > MAX_ADDR);
        bad_dat   = (lat_dat != DSZ'(exp_dat));

        bad_kind                   = '0;
        bad_kind[NS_CHK_BIT_REDUN] = bad_redun;
        bad_kind[NS_CHK_BIT_DST]   = bad_dst;
        bad_kind[NS_CHK_BIT_DAT]   = bad_dat;
    end

    // Handshake / check FSM. All outputs are registered here.
    // The ack is raised from inside ACK rather than on entry, so a message
    // always sees two edges between latch and ack even with ACK_DLY = 0.
    // A request that vanishes before ack is not aborted: the message
    // completes, ack rises, and drops on the next edge since req is low.
    // First-error capture keys off o_err still being clear, because o_err
    // is exactly "some failure has already been recorded".
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= NS_CHK_IDLE;
            o_ack       <= NS_OFF;
            o_ck_dat    <= DSZ'(NS_CHK_RST_CK_DAT);
            o_cnt       <= '0;
            o_err       <= NS_OFF;
            o_err_kind  <= '0;
            fst_err_inp <= '0;
            fst_err_dat <= '0;
            lat_src     <= '0;
            lat_dst     <= '0;
            lat_dat     <= '0;
            lat_red     <= '0;
            exp_dst     <= RST_EXP_DST;
            exp_dat     <= '0;
            hold_cnt    <= '0;
        end else begin
            unique case (state)
                NS_CHK_IDLE: begin
                    if (i_req && !o_ack) begin
                        lat_src <= i_src;
                        lat_dst <= i_dst;
                        lat_dat <= i_dat;
                        lat_red <= i_red;
                        state   <= NS_CHK_CHECK;
                    end
                end

                NS_CHK_CHECK: begin
                    o_ck_dat <= lat_dat;
                    o_cnt    <= o_cnt + 1'b1;
                    exp_dst  <= ASZ'(ns_chk_nxt_addr(32'(lat_dst), MIN_ADDR, MAX_ADDR));
                    exp_dat  <= lat_dat[3:0] + 4'd1;

                    if (bad_kind != '0) begin
                        o_err      <= NS_ON;
                        o_err_kind <= o_err_kind | bad_kind;
                        if (!o_err) begin
                            fst_err_inp <= DSZ'(exp_dat);
                            fst_err_dat <= lat_dat;
                        end
                    end

                    hold_cnt <= '0;
                    if (ACK_DLY == 0) begin
                        state <= NS_CHK_ACK;
                    end else begin
                        state <= NS_CHK_HOLD;
                    end
                end

                NS_CHK_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= NS_CHK_ACK;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                NS_CHK_ACK: begin
                    if (!o_ack) begin
                        o_ack <= NS_ON;
                    end else if (!i_req) begin
                        o_ack <= NS_OFF;
                        state <= NS_CHK_IDLE;
                    end
                end

                default: begin
                    state <= NS_CHK_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pakin_chk.sv
// ---------------------------------------------------------------------------
// tb_pakin_chk
//
// Self-checking bench for pakin_chk. A message-level model keeps the
// expected destination/data, the counters and the error capture, and is
// updated once per message from the stepping rules. Directed sequences
// cover the listed scenarios; a randomized run mixes corrupted fields,
// held requests and early request drops.
// ---------------------------------------------------------------------------
module tb_pakin_chk;
    import pakin_chk_pkg::*;

    localparam int unsigned MIN_A = 1;
    localparam int unsigned MAX_A = 3;
    localparam int unsigned DLY   = 3;
    localparam int          ASZ   = NS_ADDRESS_SIZE;
    localparam int          DSZ   = NS_DATA_SIZE;
    localparam int          RSZ   = NS_REDUN_SIZE;
    localparam int          CSZ   = 16;

    logic           i_clk = 1'b0;
    logic           i_rst_n;
    logic [ASZ-1:0] i_src;
    logic [ASZ-1:0] i_dst;
    logic [DSZ-1:0] i_dat;
    logic [RSZ-1:0] i_red;
    logic           i_req;
    logic           o_ack;
    logic [DSZ-1:0] o_ck_dat;
    logic [CSZ-1:0] o_cnt;
    logic           o_err;
    logic [2:0]     o_err_kind;
    logic [DSZ-1:0] fst_err_inp;
    logic [DSZ-1:0] fst_err_dat;

    int checks = 0;
    int errors = 0;

    // Message-level model state
    int unsigned m_exp_dst;
    int unsigned m_exp_dat;
    int unsigned m_cnt;
    int unsigned m_ck_dat;
    int unsigned m_kind;
    int unsigned m_fst_inp;
    int unsigned m_fst_dat;
    bit          m_err;

    pakin_chk #(
        .MIN_ADDR (MIN_A),
        .MAX_ADDR (MAX_A),
        .ASZ      (ASZ),
        .DSZ      (DSZ),
        .RSZ      (RSZ),
        .ACK_DLY  (DLY),
        .CSZ      (CSZ)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_src       (i_src),
        .i_dst       (i_dst),
        .i_dat       (i_dat),
        .i_red       (i_red),
        .i_req       (i_req),
        .o_ack       (o_ack),
        .o_ck_dat    (o_ck_dat),
        .o_cnt       (o_cnt),
        .o_err       (o_err),
        .o_err_kind  (o_err_kind),
        .fst_err_inp (fst_err_inp),
        .fst_err_dat (fst_err_dat)
    );

    always #5 i_clk = ~i_clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input longint unsigned got,
                               input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Redundancy as an XOR of successive RSZ-bit chunks of {src,dst,dat}.
    function automatic int unsigned ref_redun(input int unsigned src,
                                              input int unsigned dst,
                                              input int unsigned dat);
        longint unsigned v;
        int unsigned r;
        v = (longint'(src) << (ASZ + DSZ)) | (longint'(dst) << DSZ) | longint'(dat);
        r = 0;
        while (v != 0) begin
            r = r ^ int'(v % (64'd1 << RSZ));
            v = v >> RSZ;
        end
        return r;
    endfunction

    function automatic int unsigned ref_nxt(input int unsigned a);
        return (a >= MAX_A) ? MIN_A : a + 1;
    endfunction

    task automatic modelReset();
        m_exp_dst = ref_nxt(MIN_A);
        m_exp_dat = 0;
        m_cnt     = 0;
        m_ck_dat  = 15;
        m_kind    = 0;
        m_fst_inp = 0;
        m_fst_dat = 0;
        m_err     = 0;
    endtask

    task automatic modelAccept(input int unsigned src, input int unsigned dst,
                               input int unsigned dat, input int unsigned red);
        int unsigned kind;
        kind = 0;
        if (ref_redun(src, dst, dat) != red) kind += 4;
        if (dst != m_exp_dst || dst < MIN_A || dst > MAX_A) kind += 2;
        if (dat != m_exp_dat) kind += 1;
        if (kind != 0) begin
            if (!m_err) begin
                m_fst_inp = m_exp_dat;
                m_fst_dat = dat;
            end
            m_err  = 1;
            m_kind = m_kind | kind;
        end
        m_cnt     = (m_cnt + 1) % (1 << CSZ);
        m_ck_dat  = dat;
        m_exp_dst = ref_nxt(dst);
        m_exp_dat = ((dat % 16) + 1) % 16;
    endtask

    task automatic checkAll();
        checkOutput("o_cnt", o_cnt, m_cnt);
        checkOutput("o_ck_dat", o_ck_dat, m_ck_dat);
        checkOutput("o_err", o_err, m_err);
        checkOutput("o_err_kind", o_err_kind, m_kind);
        checkOutput("fst_err_inp", fst_err_inp, m_fst_inp);
        checkOutput("fst_err_dat", fst_err_dat, m_fst_dat);
    endtask

    // One full handshake. Request goes up just before edge N; ack must be
    // seen at the (3+DLY)-th falling edge after that (edge N+2+DLY). With
    // early_drop the request is pulled after edge N only.
    task automatic applyStimulus(input int unsigned src, input int unsigned dst,
                                 input int unsigned dat, input int unsigned red,
                                 input bit early_drop, input int hold);
        int unsigned old_cnt;
        int k;
        old_cnt = m_cnt;
        @(negedge i_clk);
        i_src = ASZ'(src);
        i_dst = ASZ'(dst);
        i_dat = DSZ'(dat);
        i_red = RSZ'(red);
        i_req = 1'b1;
        modelAccept(src, dst, dat, red);
        k = 0;
        while (!o_ack && k < 40) begin
            @(negedge i_clk);
            k++;
            if (k == 1) checkOutput("cnt_before_check", o_cnt, old_cnt);
            if (k == 2) checkOutput("cnt_after_check", o_cnt, m_cnt);
            if (early_drop) i_req = 1'b0;
            // Latched fields must not follow the pins any more.
            i_src = ASZ'($urandom);
            i_dst = ASZ'($urandom);
            i_dat = DSZ'($urandom);
            i_red = RSZ'($urandom);
        end
        if (!o_ack) begin
            checkOutput("ack_timeout", 0, 1);
        end else begin
            checkOutput("ack_latency", k, 3 + DLY);
        end
        if (!early_drop) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge i_clk);
                checkOutput("ack_hold", o_ack, 1);
            end
        end
        i_req = 1'b0;
        @(negedge i_clk);
        checkOutput("ack_fall", o_ack, 0);
        checkAll();
    endtask

    // Correct message following the model's current expectation.
    task automatic sendGood(input int unsigned dat);
        int unsigned src;
        src = $urandom_range(0, (1 << ASZ) - 1);
        applyStimulus(src, m_exp_dst, dat, ref_redun(src, m_exp_dst, dat), 0, 0);
    endtask

    initial begin
        int unsigned src, dst, dat, red;
        int k;

        i_rst_n = 1'b0;
        i_src = '0; i_dst = '0; i_dat = '0; i_red = '0; i_req = 1'b0;
        modelReset();
        repeat (3) @(negedge i_clk);
        checkOutput("rst_ack", o_ack, 0);
        checkAll();
        i_rst_n = 1'b1;
        @(negedge i_clk);

        $display("[TB] clean sequence dat 0..15");
        for (int i = 0; i < 16; i++) sendGood(i);

        $display("[TB] corrupted redundancy on dat 3");
        for (int i = 0; i < 6; i++) begin
            src = $urandom_range(0, (1 << ASZ) - 1);
            dst = m_exp_dst;
            red = ref_redun(src, dst, i);
            if (i == 3) red = red ^ 1;
            applyStimulus(src, dst, i, red, 0, 1);
        end

        $display("[TB] wrong destination");
        sendGood(m_exp_dat);
        dst = (m_exp_dst >= MAX_A) ? MIN_A : m_exp_dst + 1;
        src = 7;
        applyStimulus(src, dst, m_exp_dat, ref_redun(src, dst, m_exp_dat), 0, 0);
        sendGood(m_exp_dat);

        $display("[TB] early request drop");
        src = 9;
        applyStimulus(src, m_exp_dst, m_exp_dat,
                      ref_redun(src, m_exp_dst, m_exp_dat), 1, 0);

        $display("[TB] randomized messages");
        for (int i = 0; i < 150; i++) begin
            src = $urandom_range(0, (1 << ASZ) - 1);
            dst = m_exp_dst;
            if ($urandom_range(0, 7) == 0) dst = $urandom_range(0, (1 << ASZ) - 1);
            dat = m_exp_dat;
            if ($urandom_range(0, 7) == 0) dat = $urandom_range(0, (1 << DSZ) - 1);
            red = ref_redun(src, dst, dat);
            if ($urandom_range(0, 7) == 0) red = $urandom_range(0, (1 << RSZ) - 1);
            applyStimulus(src, dst, dat, red, ($urandom_range(0, 9) == 0),
                          $urandom_range(0, 2));
        end

        $display("[TB] reset while ack is high");
        @(negedge i_clk);
        src = 5;
        i_src = ASZ'(src);
        i_dst = ASZ'(m_exp_dst);
        i_dat = DSZ'(m_exp_dat);
        i_red = RSZ'(ref_redun(src, m_exp_dst, m_exp_dat));
        i_req = 1'b1;
        k = 0;
        while (!o_ack && k < 40) begin
            @(negedge i_clk);
            k++;
        end
        checkOutput("ack_before_reset", o_ack, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst_ack", o_ack, 0);
        checkAll();
        i_req = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        $display("[TB] post-reset sequence with skipped dat 5");
        for (int i = 0; i <= 4; i++) sendGood(i);
        sendGood(6);
        sendGood(7);
        checkOutput("skip_fst_inp", fst_err_inp, 5);
        checkOutput("skip_fst_dat", fst_err_dat, 6);
        checkOutput("skip_kind", o_err_kind, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
